// File: rtl/busmem_pkg.sv
// Shared definitions for the busmem Unibus slave memory: FSM states, register
// map, timing constants and bus-control decoding helpers.
package busmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DESKEW,
        ST_NOMATCH,
        ST_ACCESS,
        ST_SETTLE,
        ST_SSYN
    } state_t;

    localparam logic [31:0] ID_WORD = 32'h424D2001;
    localparam logic [31:0] BAD_REG = 32'hDEADBEEF;

    localparam int DESKEW_CYCLES = 8;
    localparam int SETTLE_CYCLES = 8;

    // Page 076/077 is the Unibus I/O page; a base there is never answered.
    localparam logic [5:0] IO_PAGE_BASE = 6'o76;

    localparam logic [2:0] REG_ID      = 3'd0;
    localparam logic [2:0] REG_WIN     = 3'd1;
    localparam logic [2:0] REG_ARMCTL  = 3'd2;
    localparam logic [2:0] REG_ARMDATA = 3'd3;
    localparam logic [2:0] REG_COUNT   = 3'd4;

    localparam logic [1:0] C_DATI  = 2'b00;
    localparam logic [1:0] C_DATIP = 2'b01;
    localparam logic [1:0] C_DATO  = 2'b10;
    localparam logic [1:0] C_DATOB = 2'b11;

    function automatic logic bus_is_write(input logic [1:0] c);
        return c[1];
    endfunction

    // Byte lanes written by a bus cycle; DATOB picks the lane from address bit 0.
    function automatic logic [1:0] bus_byte_en(input logic [1:0] c, input logic a0);
        case (c)
            C_DATO:  return 2'b11;
            C_DATOB: return a0 ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/busmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module busmem_ram
    import busmem_pkg::*;
#(
    parameter int NWORDS = 2048,
    parameter int AW     = 11
) (
    input  logic          CLOCK,
    input  logic          en,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [NWORDS];

    // Read data only changes on a read access, so it stays valid while idle.
    always_ff @(posedge CLOCK) begin
        if (en) begin
            if (we) begin
                if (be[0]) mem[addr][7:0]  <= wdata[7:0];
                if (be[1]) mem[addr][15:8] <= wdata[15:8];
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/busmem.sv
// Unibus slave memory window with an ARM-side register file; the ARM side can
// read or write the same RAM when the bus slave is not using it.
module busmem
    import busmem_pkg::*;
#(
    parameter int NWORDS = 2048
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [2:0]  armraddr,
    input  logic [2:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic [17:0] a_in_h,
    input  logic [1:0]  c_in_h,
    input  logic [15:0] d_in_h,
    input  logic        msyn_in_h,
    input  logic        init_in_h,
    output logic [15:0] d_out_h,
    output logic        ssyn_out_h
);

    localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    state_t      state;
    logic [2:0]  phase_cnt;
    logic        bus_rd;
    logic [31:0] cycle_count;

    logic        enable;
    logic [5:0]  base;
    logic        armbusy;
    logic        armwr;
    logic        arm_pend;
    logic [10:0] waddr;
    logic [15:0] arm_data;

    logic          ram_en;
    logic          ram_we;
    logic [1:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata;

    logic bus_acc;
    logic arm_go;
    logic addr_match;
    logic bus_done;
    logic wr_win;
    logic wr_ctl;
    logic wr_data;
    logic wr_count;
    logic unused_bits;

    assign unused_bits = ^armwdata[29:16];

    assign wr_win   = armwrite && (armwaddr == REG_WIN);
    assign wr_ctl   = armwrite && (armwaddr == REG_ARMCTL);
    assign wr_data  = armwrite && (armwaddr == REG_ARMDATA);
    assign wr_count = armwrite && (armwaddr == REG_COUNT);

    assign addr_match = enable && (a_in_h[17:12] == base) && (base < IO_PAGE_BASE);
    assign bus_done   = (state == ST_SSYN) && !msyn_in_h && !init_in_h;

    // The bus owns the RAM only in ACCESS; the ARM may use it only in IDLE or
    // NOMATCH, so the two can never collide and the bus always wins.
    always_comb begin
        bus_acc   = (state == ST_ACCESS) && !init_in_h;
        arm_go    = armbusy && !arm_pend && ((state == ST_IDLE) || (state == ST_NOMATCH));
        ram_en    = bus_acc || arm_go;
        ram_we    = 1'b0;
        ram_be    = 2'b00;
        ram_addr  = AW'(waddr);
        ram_wdata = arm_data;
        if (bus_acc) begin
            ram_we    = bus_is_write(c_in_h);
            ram_be    = bus_byte_en(c_in_h, a_in_h[0]);
            ram_addr  = AW'(a_in_h[11:1]);
            ram_wdata = d_in_h;
        end else if (arm_go) begin
            ram_we    = armwr;
            ram_be    = armwr ? 2'b11 : 2'b00;
        end
    end

    busmem_ram #(
        .NWORDS (NWORDS),
        .AW     (AW)
    ) u_ram (
        .CLOCK (CLOCK),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            phase_cnt   <= '0;
            bus_rd      <= 1'b0;
            d_out_h     <= '0;
            ssyn_out_h  <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (init_in_h) begin
                state      <= ST_IDLE;
                phase_cnt  <= '0;
                d_out_h    <= '0;
                ssyn_out_h <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (msyn_in_h) begin
                            state     <= ST_DESKEW;
                            phase_cnt <= '0;
                        end
                    end
                    ST_DESKEW: begin
                        if (!msyn_in_h) begin
                            state <= ST_IDLE;
                        end else if (phase_cnt == 3'(DESKEW_CYCLES - 1)) begin
                            state <= addr_match ? ST_ACCESS : ST_NOMATCH;
                        end else begin
                            phase_cnt <= phase_cnt + 3'd1;
                        end
                    end
                    ST_NOMATCH: begin
                        if (!msyn_in_h) state <= ST_IDLE;
                    end
                    ST_ACCESS: begin
                        state     <= ST_SETTLE;
                        phase_cnt <= '0;
                        bus_rd    <= !bus_is_write(c_in_h);
                    end
                    ST_SETTLE: begin
                        if (bus_rd) d_out_h <= ram_rdata;
                        if (phase_cnt == 3'(SETTLE_CYCLES - 1)) begin
                            state      <= ST_SSYN;
                            ssyn_out_h <= 1'b1;
                        end else begin
                            phase_cnt <= phase_cnt + 3'd1;
                        end
                    end
                    ST_SSYN: begin
                        if (!msyn_in_h) begin
                            state      <= ST_IDLE;
                            d_out_h    <= '0;
                            ssyn_out_h <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
            if (wr_count) begin
                cycle_count <= '0;
            end else if (bus_done) begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end

    // ARM request: issue one RAM cycle, then retire it the following cycle.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            enable   <= 1'b0;
            base     <= '0;
            armbusy  <= 1'b0;
            armwr    <= 1'b0;
            arm_pend <= 1'b0;
            waddr    <= '0;
            arm_data <= '0;
        end else begin
            if (wr_win) begin
                enable <= armwdata[31];
                base   <= armwdata[5:0];
            end
            if (arm_pend) begin
                armbusy  <= 1'b0;
                arm_pend <= 1'b0;
                if (!armwr) arm_data <= ram_rdata;
            end else if (arm_go) begin
                arm_pend <= 1'b1;
            end else if (wr_ctl && !armbusy) begin
                armwr   <= armwdata[30];
                waddr   <= armwdata[10:0];
                armbusy <= 1'b1;
            end
            if (wr_data && !armbusy) arm_data <= armwdata[15:0];
        end
    end

    always_comb begin
        case (armraddr)
            REG_ID:      armrdata = ID_WORD;
            REG_WIN:     armrdata = {enable, 25'b0, base};
            REG_ARMCTL:  armrdata = {armbusy, armwr, 19'b0, waddr};
            REG_ARMDATA: armrdata = {16'b0, arm_data};
            REG_COUNT:   armrdata = cycle_count;
            default:     armrdata = BAD_REG;
        endcase
    end

endmodule

// File: tb/tb_busmem.sv
// Bench for busmem: reset/register checks, a table of bus cycles, multi-cycle
// corner sequences and a randomized phase against a word-array memory model.
module tb_busmem;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        armwrite;
    logic [2:0]  armraddr;
    logic [2:0]  armwaddr;
    logic [31:0] armwdata;
    logic [31:0] armrdata;
    logic [17:0] a_in_h;
    logic [1:0]  c_in_h;
    logic [15:0] d_in_h;
    logic        msyn_in_h;
    logic        init_in_h;
    logic [15:0] d_out_h;
    logic        ssyn_out_h;

    always #5 CLOCK = ~CLOCK;

    busmem #(.NWORDS(2048)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .armwrite   (armwrite),
        .armraddr   (armraddr),
        .armwaddr   (armwaddr),
        .armwdata   (armwdata),
        .armrdata   (armrdata),
        .a_in_h     (a_in_h),
        .c_in_h     (c_in_h),
        .d_in_h     (d_in_h),
        .msyn_in_h  (msyn_in_h),
        .init_in_h  (init_in_h),
        .d_out_h    (d_out_h),
        .ssyn_out_h (ssyn_out_h)
    );

    typedef struct {
        logic [1:0]  c;
        logic [17:0] a;
        logic [15:0] d;
        bit          ack;
        logic [15:0] rd;
    } vec_t;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic rd_reg(input logic [2:0] r, output logic [31:0] v);
        armraddr = r;
        #1;
        v = armrdata;
    endtask

    task automatic arm_wr(input logic [2:0] r, input logic [31:0] v);
        armwaddr = r;
        armwdata = v;
        armwrite = 1'b1;
        tick();
        armwrite = 1'b0;
    endtask

    task automatic bus_cycle(input logic [1:0] c, input logic [17:0] a, input logic [15:0] d,
                             input int budget, output bit got, output int lat,
                             output logic [15:0] rd);
        got = 0;
        lat = 0;
        c_in_h = c;
        a_in_h = a;
        d_in_h = d;
        msyn_in_h = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (ssyn_out_h) begin
                got = 1;
                lat = i;
                break;
            end
        end
        rd = d_out_h;
        msyn_in_h = 1'b0;
        tick();
    endtask

    task automatic check_bus(input string name, input logic [1:0] c, input logic [17:0] a,
                             input logic [15:0] d, input bit ack, input logic [15:0] exp_rd,
                             input int nm_budget);
        bit got;
        int lat;
        logic [15:0] rd;
        logic [31:0] v;
        bus_cycle(c, a, d, ack ? 40 : nm_budget, got, lat, rd);
        chk({name, ".ack"}, 32'(got), 32'(ack));
        if (ack && got) chk({name, ".lat"}, 32'(lat), 32'd18);
        chk({name, ".dout"}, {16'b0, rd}, {16'b0, exp_rd});
        chk({name, ".rel"}, {15'b0, ssyn_out_h, d_out_h}, 32'd0);
        if (ack) exp_cnt++;
        rd_reg(3'd4, v);
        chk({name, ".cnt"}, v, 32'(exp_cnt));
        tick();
    endtask

    task automatic wait_arm(input string name);
        logic [31:0] v;
        bit done;
        done = 0;
        for (int i = 0; i < 20; i++) begin
            rd_reg(3'd2, v);
            if (!v[31]) begin
                done = 1;
                break;
            end
            tick();
        end
        chk({name, ".armdone"}, 32'(done), 32'd1);
    endtask

    // DATI from page 1 word 0 with an ARM register write slipped in mid-SETTLE.
    task automatic dati_with_write(input string name, input logic [2:0] r, input logic [31:0] val,
                                   input int pre, output int n);
        bit got;
        got = 0;
        n = 0;
        c_in_h = 2'b00;
        a_in_h = 18'o010000;
        msyn_in_h = 1'b1;
        for (int i = 0; i < pre; i++) begin
            tick();
            n++;
        end
        arm_wr(r, val);
        n++;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            n++;
            if (ssyn_out_h) got = 1;
        end
        chk({name, ".ack"}, 32'(got), 32'd1);
        chk({name, ".lat"}, 32'(n), 32'd18);
        chk({name, ".dout"}, {16'b0, d_out_h}, {16'b0, 16'o177652});
    endtask

    initial begin
        vec_t        vt[8];
        logic [31:0] v;
        logic [15:0] mem_m [16];
        logic [5:0]  base_m;
        logic [5:0]  page;
        logic [3:0]  w;
        logic [1:0]  c;
        logic [15:0] dat;
        logic [15:0] exp_rd;
        logic        bsel;
        bit          match;
        bit          seen;
        int          n;
        int          r;

        vt[0] = '{2'b10, 18'o010000, 16'o123456, 1'b1, 16'o000000};
        vt[1] = '{2'b00, 18'o010000, 16'o000000, 1'b1, 16'o123456};
        vt[2] = '{2'b10, 18'o010000, 16'o000000, 1'b1, 16'o000000};
        vt[3] = '{2'b11, 18'o010001, 16'o177400, 1'b1, 16'o000000};
        vt[4] = '{2'b00, 18'o010000, 16'o000000, 1'b1, 16'o177400};
        vt[5] = '{2'b11, 18'o010000, 16'o000252, 1'b1, 16'o000000};
        vt[6] = '{2'b01, 18'o010000, 16'o000000, 1'b1, 16'o177652};
        vt[7] = '{2'b00, 18'o020000, 16'o000000, 1'b0, 16'o000000};

        // Reset held together with a register write and INIT: reset must win.
        RESET = 1'b1;
        armwrite = 1'b1;
        armwaddr = 3'd1;
        armwdata = 32'h8000_0001;
        armraddr = 3'd0;
        a_in_h = '0;
        c_in_h = '0;
        d_in_h = '0;
        msyn_in_h = 1'b0;
        init_in_h = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        armwrite = 1'b0;
        init_in_h = 1'b0;
        tick();

        chk("rst.ssyn", 32'(ssyn_out_h), 32'd0);
        chk("rst.dout", {16'b0, d_out_h}, 32'd0);
        rd_reg(3'd0, v); chk("rst.id", v, 32'h424D2001);
        rd_reg(3'd1, v); chk("rst.win", v, 32'd0);
        rd_reg(3'd2, v); chk("rst.armctl", v, 32'd0);
        rd_reg(3'd3, v); chk("rst.armdata", v, 32'd0);
        rd_reg(3'd4, v); chk("rst.count", v, 32'd0);
        rd_reg(3'd5, v); chk("rst.reg5", v, 32'hDEADBEEF);
        rd_reg(3'd7, v); chk("rst.reg7", v, 32'hDEADBEEF);

        arm_wr(3'd1, 32'h8000_0001);
        rd_reg(3'd1, v); chk("win.set", v, 32'h8000_0001);

        for (int i = 0; i < 8; i++) begin
            check_bus($sformatf("vec%0d", i), vt[i].c, vt[i].a, vt[i].d, vt[i].ack, vt[i].rd, 1000);
        end

        arm_wr(3'd1, 32'h8000_003E);
        check_bus("iopage", 2'b00, 18'o760000, 16'h0, 1'b0, 16'h0, 1000);
        arm_wr(3'd1, 32'h8000_0001);

        // ARM write; a data-register write while busy must not disturb it.
        arm_wr(3'd3, 32'h0000_1234);
        arm_wr(3'd2, {1'b0, 1'b1, 19'b0, 11'd5});
        arm_wr(3'd3, 32'h0000_FFFF);
        wait_arm("armw");
        rd_reg(3'd3, v); chk("armw.reg3", v, 32'h0000_1234);
        check_bus("armw.bus", 2'b00, 18'o010012, 16'h0, 1'b1, 16'h1234, 40);

        // ARM read of word 5 requested during SETTLE of a bus read of word 0.
        dati_with_write("settle", 3'd2, {2'b00, 19'b0, 11'd5}, 12, n);
        rd_reg(3'd2, v); chk("settle.busy_ssyn", 32'(v[31]), 32'd1);
        msyn_in_h = 1'b0;
        tick();
        exp_cnt++;
        rd_reg(3'd2, v); chk("settle.busy_end", 32'(v[31]), 32'd1);
        wait_arm("settle");
        rd_reg(3'd3, v); chk("settle.reg3", v, 32'h0000_1234);
        rd_reg(3'd4, v); chk("settle.cnt", v, 32'(exp_cnt));
        tick();

        // Clearing enable after decode lets the cycle finish; the next is ignored.
        dati_with_write("endis", 3'd1, 32'h0000_0001, 12, n);
        msyn_in_h = 1'b0;
        tick();
        exp_cnt++;
        tick();
        check_bus("disabled", 2'b00, 18'o010000, 16'h0, 1'b0, 16'h0, 40);
        arm_wr(3'd1, 32'h8000_0001);

        // INIT while in SSYN, dropping MSYN in the same cycle.
        dati_with_write("init", 3'd6, 32'h0, 0, n);
        repeat (3) tick();
        chk("init.hold_ssyn", 32'(ssyn_out_h), 32'd1);
        chk("init.hold_dout", {16'b0, d_out_h}, {16'b0, 16'o177652});
        init_in_h = 1'b1;
        msyn_in_h = 1'b0;
        tick();
        init_in_h = 1'b0;
        chk("init.out", {15'b0, ssyn_out_h, d_out_h}, 32'd0);
        tick();
        rd_reg(3'd4, v); chk("init.cnt", v, 32'(exp_cnt));
        check_bus("post_init", 2'b00, 18'o010000, 16'h0, 1'b1, 16'o177652, 40);

        // Short MSYN pulse: deskew aborts, no reply, RAM untouched.
        c_in_h = 2'b10;
        a_in_h = 18'o010000;
        d_in_h = 16'o055555;
        msyn_in_h = 1'b1;
        repeat (5) tick();
        msyn_in_h = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ssyn_out_h) seen = 1;
        end
        chk("pulse.nossyn", 32'(seen), 32'd0);
        rd_reg(3'd4, v); chk("pulse.cnt", v, 32'(exp_cnt));
        check_bus("pulse.ram", 2'b00, 18'o010000, 16'h0, 1'b1, 16'o177652, 40);

        // Randomized phase: model is a plain word array plus the window rule.
        base_m = 6'd1;
        for (int i = 0; i < 16; i++) begin
            w = 4'(i);
            dat = 16'($urandom);
            check_bus("fill", 2'b10, {6'd1, 7'd0, w, 1'b0}, dat, 1'b1, 16'h0, 40);
            mem_m[i] = dat;
        end
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            w = 4'($urandom_range(0, 15));
            dat = 16'($urandom);
            if (r == 0) begin
                base_m = ($urandom_range(0, 1) == 1) ? 6'd2 : 6'd1;
                arm_wr(3'd1, {1'b1, 25'b0, base_m});
            end else if (r == 1) begin
                arm_wr(3'd3, {16'b0, dat});
                arm_wr(3'd2, {1'b0, 1'b1, 19'b0, 7'd0, w});
                wait_arm("rnd.armw");
                mem_m[w] = dat;
            end else if (r == 2) begin
                arm_wr(3'd2, {2'b00, 19'b0, 7'd0, w});
                wait_arm("rnd.armr");
                rd_reg(3'd3, v);
                chk("rnd.armrd", v, {16'b0, mem_m[w]});
            end else begin
                page = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : base_m;
                c = 2'($urandom_range(0, 3));
                bsel = 1'($urandom_range(0, 1));
                match = (page == base_m) && (base_m < 6'o76);
                exp_rd = (match && !c[1]) ? mem_m[w] : 16'h0;
                check_bus("rnd.bus", c, {page, 7'd0, w, bsel}, dat, match, exp_rd, 40);
                if (match && c == 2'b10) mem_m[w] = dat;
                if (match && c == 2'b11) begin
                    if (bsel) mem_m[w][15:8] = dat[15:8];
                    else      mem_m[w][7:0]  = dat[7:0];
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
